// File: rtl/fetch_controller_pkg.sv
// Shared definitions for the instruction fetch front end.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Contents: FSM state encoding and the end-of-program marker word.
package fetch_controller_pkg;

    // Fetch FSM state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    // A fetched word equal to this marks the end of the program text
    localparam logic [31:0] EOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/fetch_controller_queue.sv
// Two-entry FIFO holding fetched {pc, instruction} pairs.
// Latency: one edge from push to head visibility.
// Backpressure: push is accepted only with space free or a pop in the same cycle.
// Ports: clk/rst_n; i_push/i_push_dat write side; i_pop read side;
//        i_flush empties the queue and overrides push/pop; o_head_dat, o_count.
module fetch_queue #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_head_dat,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;

    logic w_pop_ok;
    logic w_push_ok;

    assign w_pop_ok  = i_pop && (r_count != 2'd0) && !i_flush;
    // A full queue still accepts a push when the head leaves the same cycle
    assign w_push_ok = i_push && ((r_count != 2'd2) || w_pop_ok) && !i_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push_ok) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop_ok)  r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, w_push_ok} - {1'b0, w_pop_ok};
        end
    end

    // Storage is not reset; count/pointers alone define validity
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_push_dat;
    end

    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_count    = r_count;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: walks text memory and feeds a 2-deep prefetch queue.
// Latency: first instruction valid two edges after run request or redirect.
// Backpressure: instr_ready low stalls the queue; fetch stops when it is full.
// Ports: clk/rst_n; fetch_en run request; redirect_valid/redirect_pc branch target;
//        rom_addr/rom_data zero-latency text memory; instr_* valid/ready output; halted.
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    PC_WIDTH   = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_en,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [PC_WIDTH-1:0]   instr_pc,
    output logic                  halted
);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [PC_WIDTH-1:0] r_fetch_pc;

    logic [1:0]                     w_count;
    logic [PC_WIDTH+DATA_WIDTH-1:0] w_head_dat;
    logic                           w_pop;
    logic                           w_space;
    logic                           w_fetch;
    logic                           w_eop;
    logic                           w_push;

    // Memory is word addressed; the PC is a byte address
    assign rom_addr = r_fetch_pc[ADDR_WIDTH+1:2];

    assign instr_valid = (w_count != 2'd0);
    assign w_pop       = instr_valid && instr_ready;
    assign w_space     = (w_count != 2'd2) || w_pop;
    // Redirect wins over fetching: the fetched word belongs to the old path
    assign w_fetch     = (r_state == ST_RUN) && fetch_en && !redirect_valid && w_space;
    assign w_eop       = (rom_data == DATA_WIDTH'(EOP_WORD));
    assign w_push      = w_fetch && !w_eop;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (fetch_en) w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (!fetch_en)            w_state_nxt = ST_IDLE;
                else if (w_fetch && w_eop) w_state_nxt = ST_HALTED;
            end
            ST_HALTED: w_state_nxt = ST_HALTED;
            default:   w_state_nxt = ST_IDLE;
        endcase
        if (redirect_valid) w_state_nxt = fetch_en ? ST_RUN : ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_fetch_pc <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            if (redirect_valid)
                r_fetch_pc <= redirect_pc & ~PC_WIDTH'(3);
            else if (w_push)
                r_fetch_pc <= r_fetch_pc + PC_WIDTH'(4);
            // End-of-program fetch leaves the PC on the marker word
        end
    end

    fetch_queue #(
        .WIDTH (PC_WIDTH + DATA_WIDTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_push),
        .i_push_dat ({r_fetch_pc, rom_data}),
        .i_pop      (w_pop),
        .i_flush    (redirect_valid),
        .o_head_dat (w_head_dat),
        .o_count    (w_count)
    );

    assign instr_pc   = w_head_dat[PC_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
    assign instr_data = w_head_dat[DATA_WIDTH-1:0];
    assign halted     = (r_state == ST_HALTED);

endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;

    logic        clk;
    logic        rst_n, fetch_en, redirect_valid, instr_ready;
    logic [31:0] redirect_pc;
    logic [7:0]  rom_addr;
    logic [31:0] rom_data, instr_data, instr_pc;
    logic        instr_valid, halted;

    logic        rst_n_b, fetch_en_b, redirect_valid_b, instr_ready_b;
    logic [31:0] redirect_pc_b;
    logic [7:0]  rom_addr_b;
    logic [31:0] rom_data_b, instr_data_b, instr_pc_b;
    logic        instr_valid_b, halted_b;

    logic [31:0] mem [0:255];
    logic [63:0] exp_q [$];
    logic [31:0] last_pc;
    int          n_checks = 0;
    int          n_errors = 0;

    assign rom_data   = mem[rom_addr];
    assign rom_data_b = mem[rom_addr_b];

    fetch_controller dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_pc(instr_pc), .halted(halted)
    );

    fetch_controller #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n_b), .fetch_en(fetch_en_b),
        .redirect_valid(redirect_valid_b), .redirect_pc(redirect_pc_b),
        .rom_addr(rom_addr_b), .rom_data(rom_data_b),
        .instr_valid(instr_valid_b), .instr_ready(instr_ready_b),
        .instr_data(instr_data_b), .instr_pc(instr_pc_b), .halted(halted_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push_range(input logic [31:0] start, input int n);
        logic [31:0] pc;
        pc = start;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({pc, mem[pc[9:2]]});
            pc = pc + 32'd4;
        end
    endtask

    task automatic wait_halt(input string tag);
        int n = 0;
        while (!halted && n < 50) begin tick(); n++; end
        check(tag, {63'd0, halted}, 64'd1);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (instr_valid && n < 50) begin tick(); n++; end
        check(tag, {63'd0, instr_valid}, 64'd0);
    endtask

    // Scoreboard monitor: every accepted instruction must be the next expected one
    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pop", {instr_pc, instr_data}, 64'd0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("sb_pc", {32'd0, instr_pc}, {32'd0, e[63:32]});
                check("sb_data", {32'd0, instr_data}, {32'd0, e[31:0]});
                last_pc = instr_pc;
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 | i;
        mem[0]  = 32'h0005_2503;
        mem[1]  = 32'h0045_a583;
        mem[8]  = 32'h0000_0000;
        mem[12] = 32'h00c6_f6b3;
        mem[13] = 32'h00c6_e733;
        mem[16] = 32'h0000_0000;

        rst_n = 0; fetch_en = 0; redirect_valid = 0; redirect_pc = 0; instr_ready = 0;
        rst_n_b = 0; fetch_en_b = 0; redirect_valid_b = 0; redirect_pc_b = 0; instr_ready_b = 0;
        last_pc = 32'hDEAD_BEEF;

        // Reset state and free-running fetch up to the end-of-program marker
        tick(); tick();
        check("rst_valid",  {63'd0, instr_valid}, 64'd0);
        check("rst_halted", {63'd0, halted}, 64'd0);
        check("rst_addr",   {56'd0, rom_addr}, 64'd0);
        sb_push_range(32'h0, 8);
        rst_n = 1; fetch_en = 1; instr_ready = 1;
        tick();
        check("lat_edge1_valid", {63'd0, instr_valid}, 64'd0);
        tick();
        check("lat_edge2_valid", {63'd0, instr_valid}, 64'd1);
        check("lat_edge2_pc",    {32'd0, instr_pc}, 64'h0);
        check("lat_edge2_data",  {32'd0, instr_data}, 64'h0005_2503);
        wait_halt("halt1");
        wait_drain("drain1");
        check("halt1_last_pc", {32'd0, last_pc}, 64'h1C);
        check("halt1_sb_empty", exp_q.size(), 64'd0);
        check("halt1_pc_hold", {56'd0, rom_addr}, 64'd8);

        // Redirect out of HALTED
        redirect_valid = 1; redirect_pc = 32'h30;
        sb_push_range(32'h30, 4);
        tick();
        redirect_valid = 0;
        check("redir1_valid_e1", {63'd0, instr_valid}, 64'd0);
        check("redir1_halted",   {63'd0, halted}, 64'd0);
        tick();
        check("redir1_valid_e2", {63'd0, instr_valid}, 64'd1);
        check("redir1_pc",       {32'd0, instr_pc}, 64'h30);
        check("redir1_data",     {32'd0, instr_data}, 64'h00c6_f6b3);
        tick();
        check("redir1_data2",    {32'd0, instr_data}, 64'h00c6_e733);
        wait_halt("halt2");
        wait_drain("drain2");
        check("halt2_sb_empty", exp_q.size(), 64'd0);

        // Backpressure: fill, hold, release
        rst_n = 0; fetch_en = 0; instr_ready = 0;
        #1;
        check("rst2_valid",  {63'd0, instr_valid}, 64'd0);
        check("rst2_halted", {63'd0, halted}, 64'd0);
        exp_q.delete();
        sb_push_range(32'h0, 3);
        tick();
        rst_n = 1; fetch_en = 1;
        tick(); tick(); tick();
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", {63'd0, instr_valid}, 64'd1);
            check("stall_pc",    {32'd0, instr_pc}, 64'h0);
            check("stall_data",  {32'd0, instr_data}, 64'h0005_2503);
            tick();
        end
        check("stall_fetch_stopped", {56'd0, rom_addr}, 64'd2);
        instr_ready = 1;
        tick(); tick(); tick();
        check("release_sb_empty", exp_q.size(), 64'd0);

        // Redirect while full and ready: flush wins, nothing popped
        exp_q.delete();
        sb_push_range(32'h30, 4);
        redirect_valid = 1; redirect_pc = 32'h33;
        tick();
        redirect_valid = 0;
        check("redir2_valid_e1", {63'd0, instr_valid}, 64'd0);
        tick();
        check("redir2_valid_e2", {63'd0, instr_valid}, 64'd1);
        check("redir2_pc",       {32'd0, instr_pc}, 64'h30);
        wait_halt("halt3");
        wait_drain("drain3");
        check("halt3_sb_empty", exp_q.size(), 64'd0);

        // PC wrap from a top-of-space reset vector, then reset while full
        rst_n_b = 1; fetch_en_b = 1; instr_ready_b = 1;
        tick();
        check("wrap_e1_valid", {63'd0, instr_valid_b}, 64'd0);
        tick();
        check("wrap_e2_valid", {63'd0, instr_valid_b}, 64'd1);
        check("wrap_pc0",      {32'd0, instr_pc_b}, 64'hFFFF_FFFC);
        check("wrap_data0",    {32'd0, instr_data_b}, {32'd0, mem[255]});
        tick();
        check("wrap_pc1",      {32'd0, instr_pc_b}, 64'h0);
        check("wrap_data1",    {32'd0, instr_data_b}, 64'h0005_2503);
        instr_ready_b = 0;
        tick(); tick();
        check("wrap_full_valid", {63'd0, instr_valid_b}, 64'd1);
        rst_n_b = 0;
        #1;
        check("midrst_valid", {63'd0, instr_valid_b}, 64'd0);
        check("midrst_pc",    {56'd0, rom_addr_b}, 64'hFF);
        fetch_en_b = 0;
        tick();
        rst_n_b = 1;
        tick(); tick(); tick();
        check("postrst_valid", {63'd0, instr_valid_b}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, instruction word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, text-memory word-address width.
REQ-003 SHALL have parameter PC_WIDTH, default 32, byte-address PC width.
REQ-004 SHALL have parameter RESET_PC, default 0, byte address of first fetch after reset.
REQ-005 SHALL have ports: clk in 1 (single clock); rst_n in 1 (asynchronous, active-low reset).
REQ-006 SHALL have ports: fetch_en in 1, run request; redirect_valid in 1, branch/jump request; redirect_pc in PC_WIDTH, target byte address.
REQ-007 SHALL have ports: rom_addr out ADDR_WIDTH, word address to text memory; rom_data in DATA_WIDTH, combinational read data.
REQ-008 SHALL have ports: instr_valid out 1; instr_ready in 1; instr_data out DATA_WIDTH; instr_pc out PC_WIDTH; halted out 1.

Function
REQ-009 SHALL drive rom_addr = fetch_pc[ADDR_WIDTH+1:2] combinationally; text memory is treated as zero-latency.
REQ-010 SHALL implement FSM states IDLE, RUN, HALTED; halted = (state == HALTED).
REQ-011 IDLE->RUN on edge with fetch_en=1; RUN->IDLE on edge with fetch_en=0; RUN->HALTED on edge where a fetch reads rom_data == 0 (end-of-program marker); HALTED->RUN only on redirect_valid.
REQ-012 In RUN, with no redirect and queue space (count<2, or count==2 with pop this cycle), SHALL push {fetch_pc, rom_data} and advance fetch_pc by 4.
REQ-013 The all-zero word SHALL NOT be pushed; fetch_pc holds its value on entering HALTED.
REQ-014 Prefetch queue SHALL be 2 entries, FIFO order; instr_valid = (count != 0); instr_data/instr_pc = head entry.
REQ-015 Pop occurs when instr_valid && instr_ready; simultaneous push and pop SHALL be permitted at every count, count unchanged.
REQ-016 Outputs SHALL NOT change while instr_valid=1 and instr_ready=0 (stable-until-accepted).
REQ-017 redirect_valid SHALL take priority over push and pop in the same cycle: queue flushed (count=0), fetch_pc <= {redirect_pc[PC_WIDTH-1:2], 2'b00}, no push that cycle, state -> RUN if fetch_en=1 else IDLE.
REQ-018 First redirected instruction SHALL appear at instr_valid two edges after the redirect edge (one edge redirect, one edge fetch+push).
REQ-019 fetch_pc SHALL wrap modulo 2^PC_WIDTH; rom_addr wraps naturally modulo 2^ADDR_WIDTH.
REQ-020 fetch_en=0 SHALL stop pushes but SHALL NOT flush the queue; pops continue.

Reset
REQ-021 On rst_n=0, asynchronously: state=IDLE, fetch_pc=RESET_PC, count=0, queue pointers=0, instr_valid=0, halted=0; queue data contents need not be cleared.
REQ-022 Reset asserted mid-operation SHALL discard all queued instructions and pending redirect; no output pulse on release.
REQ-023 After rst_n release with fetch_en=1 held: IDLE->RUN at edge 1, first push at edge 2, instr_valid=1 after edge 2.

Structure
REQ-024 FSM state encoding and the end-of-program constant (32'h00000000) SHALL reside in the shared core package.
REQ-025 The 2-entry queue SHALL be a sub-module fetch_queue (parameterised width PC_WIDTH+DATA_WIDTH, push/pop/flush, count).
REQ-026 Total RTL 120-400 lines; no combinational path from instr_ready to rom_addr.

Verification
REQ-027 Reset, fetch_en=1, instr_ready=1, memory words 0x00052503,0x0045a583,... -> instr_valid after edge 2 with pc 0x0/0x00052503, then pc 0x4/0x0045a583 each cycle.
REQ-028 instr_ready=0 for 5 cycles -> queue fills to 2, pushes stop, instr_data held at pc 0x0 word; release -> pcs 0x0,0x4,0x8 in order, none lost/duplicated.
REQ-029 redirect_valid with redirect_pc=0x33 while full and instr_ready=1 -> flush, no pop counted, next instr_pc=0x30 two edges later.
REQ-030 Fetch reaches word 8 (rom_data=0) -> halted=1, last delivered pc 0x1C, instr_valid drops once drained; redirect_pc=0x30 -> RUN, delivers 0x00c6f6b3 then 0x00c6e733.
REQ-031 RESET_PC=0xFFFFFFFC -> pcs 0xFFFFFFFC then 0x00000000 (wrap); rst_n pulsed while count=2 -> instr_valid=0 immediately, fetch_pc=RESET_PC.
